// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_pkg
//  Description : Shared definitions for the associative joint TLB: CP0 op
//                codes, EntryHi/EntryLo field positions, the stored entry
//                layout and a helper that rebuilds an EntryLo word.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlb_pkg;

    // CP0 TLB operation codes
    localparam logic [1:0] c_OP_PROBE     = 2'd0;
    localparam logic [1:0] c_OP_READ      = 2'd1;
    localparam logic [1:0] c_OP_WRITE_IDX = 2'd2;
    localparam logic [1:0] c_OP_WRITE_RND = 2'd3;

    // EntryHi field positions
    localparam int c_HI_VPN2_MSB = 31;
    localparam int c_HI_VPN2_LSB = 13;
    localparam int c_HI_ASID_MSB = 7;

    // EntryLo field positions
    localparam int c_LO_PFN_MSB = 25;
    localparam int c_LO_PFN_LSB = 6;
    localparam int c_LO_C_MSB   = 5;
    localparam int c_LO_C_LSB   = 3;
    localparam int c_LO_D       = 2;
    localparam int c_LO_V       = 1;
    localparam int c_LO_G       = 0;

    localparam logic [31:0] c_PROBE_MISS = 32'h8000_0000;

    // One half (even or odd page) of an entry
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic             present;
        logic [18:0]      vpn2;
        logic [7:0]       asid;
        logic             g;
        tlb_page_t [1:0]  page;     // page[1] = odd (vaddr[12]=1)
    } tlb_entry_t;

    // Rebuild an EntryLo word; G is reported in both halves
    function automatic logic [31:0] lo_pack(input tlb_page_t p, input logic g);
        logic [31:0] w;
        w = '0;
        w[c_LO_PFN_MSB:c_LO_PFN_LSB] = p.pfn;
        w[c_LO_C_MSB:c_LO_C_LSB]     = p.c;
        w[c_LO_D]                    = p.d;
        w[c_LO_V]                    = p.v;
        w[c_LO_G]                    = g;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_assoc_if.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_assoc_if
//  Description : Lookup and CP0 op bus of the associative TLB.
//                master = pipeline/CP0 side, slave = TLB side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tlb_assoc_if #(
    parameter int IDX_W = 4
);
    // lookup port
    logic             lk_req;
    logic [31:0]      lk_vaddr;
    logic             lk_store;
    logic             lk_valid;
    logic             lk_hit;
    logic [31:0]      lk_paddr;
    logic             lk_refill;
    logic             lk_invalid;
    logic             lk_modified;
    // CP0 op port
    logic             op_valid;
    logic [1:0]       op;
    logic [31:0]      index;
    logic [31:0]      entry_hi;
    logic [31:0]      entry_lo0;
    logic [31:0]      entry_lo1;
    logic             wired_we;
    logic [IDX_W-1:0] wired_in;
    logic             op_done;
    logic             w_index;
    logic             w_content;
    logic [31:0]      index_out;
    logic [31:0]      entry_hi_out;
    logic [31:0]      entry_lo0_out;
    logic [31:0]      entry_lo1_out;
    logic [IDX_W-1:0] random_out;

    modport master (
        output lk_req, lk_vaddr, lk_store,
        input  lk_valid, lk_hit, lk_paddr, lk_refill, lk_invalid, lk_modified,
        output op_valid, op, index, entry_hi, entry_lo0, entry_lo1, wired_we, wired_in,
        input  op_done, w_index, w_content, index_out,
        input  entry_hi_out, entry_lo0_out, entry_lo1_out, random_out
    );

    modport slave (
        input  lk_req, lk_vaddr, lk_store,
        output lk_valid, lk_hit, lk_paddr, lk_refill, lk_invalid, lk_modified,
        input  op_valid, op, index, entry_hi, entry_lo0, entry_lo1, wired_we, wired_in,
        output op_done, w_index, w_content, index_out,
        output entry_hi_out, entry_lo0_out, entry_lo1_out, random_out
    );
endinterface
`default_nettype wire

// File: rtl/tlb_match.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_match
//  Description : Combinational tag compare across all entries followed by a
//                lowest-index priority encoder.
//  Ports       : i_present/i_global/i_vpn2_tab/i_asid_tab - per-entry tags
//                i_vpn2/i_asid - key;  o_hit/o_idx - first matching entry
//  Revision    : 1.0 - initial release
// ============================================================================
module tlb_match #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int ASID_W  = 8
) (
    input  logic [ENTRIES-1:0] i_present,
    input  logic [ENTRIES-1:0] i_global,
    input  logic [18:0]        i_vpn2_tab [ENTRIES],
    input  logic [ASID_W-1:0]  i_asid_tab [ENTRIES],
    input  logic [18:0]        i_vpn2,
    input  logic [ASID_W-1:0]  i_asid,
    output logic               o_hit,
    output logic [IDX_W-1:0]   o_idx
);
    logic [ENTRIES-1:0] w_match;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign w_match[gi] = i_present[gi] && (i_vpn2_tab[gi] == i_vpn2) &&
                                 (i_global[gi] || (i_asid_tab[gi] == i_asid));
        end
    endgenerate

    // Scan from the top so the lowest matching index is the last one kept
    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_match[i]) o_idx = IDX_W'(i);
        end
    end
endmodule
`default_nettype wire

// File: rtl/tlb_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_assoc
//  Description : Fully-associative MIPS32-style joint TLB with a registered
//                one-cycle lookup, CP0 TLBP/TLBR/TLBWI/TLBWR execution and
//                internal Random/Wired registers.
//  Ports       : clk, rst (async, active high), bus (tlb_assoc_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module tlb_assoc
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int ASID_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    tlb_assoc_if.slave bus
);
    localparam logic [IDX_W-1:0] c_IDX_MAX = {IDX_W{1'b1}};

    tlb_entry_t         r_tlb [ENTRIES];
    logic [IDX_W-1:0]   r_random, r_wired;

    // Flattened tag view shared by both match instances
    logic [ENTRIES-1:0] w_present, w_global;
    logic [18:0]        w_vpn2_tab [ENTRIES];
    logic [ASID_W-1:0]  w_asid_tab [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_flat
            assign w_present[gi]  = r_tlb[gi].present;
            assign w_global[gi]   = r_tlb[gi].g;
            assign w_vpn2_tab[gi] = r_tlb[gi].vpn2;
            assign w_asid_tab[gi] = r_tlb[gi].asid[ASID_W-1:0];
        end
    endgenerate

    // ---------------- lookup path ----------------
    logic             w_lk_match, w_lk_hit;
    logic [IDX_W-1:0] w_lk_idx;
    tlb_page_t        w_lk_page;

    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) u_lk_match (
        .i_present (w_present),
        .i_global  (w_global),
        .i_vpn2_tab(w_vpn2_tab),
        .i_asid_tab(w_asid_tab),
        .i_vpn2    (bus.lk_vaddr[31:13]),
        .i_asid    (bus.entry_hi[ASID_W-1:0]),
        .o_hit     (w_lk_match),
        .o_idx     (w_lk_idx)
    );

    assign w_lk_page = r_tlb[w_lk_idx].page[bus.lk_vaddr[12]];
    assign w_lk_hit  = w_lk_match && w_lk_page.v && (!bus.lk_store || w_lk_page.d);

    logic        r_lk_valid, r_lk_hit, r_lk_refill, r_lk_invalid, r_lk_modified;
    logic [31:0] r_lk_paddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lk_valid    <= 1'b0;
            r_lk_hit      <= 1'b0;
            r_lk_paddr    <= '0;
            r_lk_refill   <= 1'b0;
            r_lk_invalid  <= 1'b0;
            r_lk_modified <= 1'b0;
        end else begin
            r_lk_valid    <= bus.lk_req;
            r_lk_hit      <= bus.lk_req && w_lk_hit;
            r_lk_paddr    <= (bus.lk_req && w_lk_hit) ? {w_lk_page.pfn, bus.lk_vaddr[11:0]} : '0;
            r_lk_refill   <= bus.lk_req && !w_lk_match;
            r_lk_invalid  <= bus.lk_req && w_lk_match && !w_lk_page.v;
            r_lk_modified <= bus.lk_req && w_lk_match && w_lk_page.v && bus.lk_store && !w_lk_page.d;
        end
    end

    assign bus.lk_valid    = r_lk_valid;
    assign bus.lk_hit      = r_lk_hit;
    assign bus.lk_paddr    = r_lk_paddr;
    assign bus.lk_refill   = r_lk_refill;
    assign bus.lk_invalid  = r_lk_invalid;
    assign bus.lk_modified = r_lk_modified;

    // ---------------- CP0 op path ----------------
    logic             w_pr_match;
    logic [IDX_W-1:0] w_pr_idx;

    tlb_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ASID_W(ASID_W)) u_pr_match (
        .i_present (w_present),
        .i_global  (w_global),
        .i_vpn2_tab(w_vpn2_tab),
        .i_asid_tab(w_asid_tab),
        .i_vpn2    (bus.entry_hi[c_HI_VPN2_MSB:c_HI_VPN2_LSB]),
        .i_asid    (bus.entry_hi[ASID_W-1:0]),
        .o_hit     (w_pr_match),
        .o_idx     (w_pr_idx)
    );

    logic             w_op_probe, w_op_read, w_op_write;
    logic [IDX_W-1:0] w_wr_idx;
    tlb_entry_t       w_new, w_rd_entry;

    assign w_op_probe = bus.op_valid && (bus.op == c_OP_PROBE);
    assign w_op_read  = bus.op_valid && (bus.op == c_OP_READ);
    assign w_op_write = bus.op_valid && ((bus.op == c_OP_WRITE_IDX) || (bus.op == c_OP_WRITE_RND));
    // WRITE_RND uses Random as it stands before this edge, even if Wired loads now
    assign w_wr_idx   = (bus.op == c_OP_WRITE_RND) ? r_random : bus.index[IDX_W-1:0];
    assign w_rd_entry = r_tlb[bus.index[IDX_W-1:0]];

    always_comb begin
        w_new              = '0;
        w_new.present      = 1'b1;
        w_new.vpn2         = bus.entry_hi[c_HI_VPN2_MSB:c_HI_VPN2_LSB];
        w_new.asid         = bus.entry_hi[c_HI_ASID_MSB:0];
        w_new.g            = bus.entry_lo0[c_LO_G] & bus.entry_lo1[c_LO_G];
        w_new.page[0].pfn  = bus.entry_lo0[c_LO_PFN_MSB:c_LO_PFN_LSB];
        w_new.page[0].c    = bus.entry_lo0[c_LO_C_MSB:c_LO_C_LSB];
        w_new.page[0].d    = bus.entry_lo0[c_LO_D];
        w_new.page[0].v    = bus.entry_lo0[c_LO_V];
        w_new.page[1].pfn  = bus.entry_lo1[c_LO_PFN_MSB:c_LO_PFN_LSB];
        w_new.page[1].c    = bus.entry_lo1[c_LO_C_MSB:c_LO_C_LSB];
        w_new.page[1].d    = bus.entry_lo1[c_LO_D];
        w_new.page[1].v    = bus.entry_lo1[c_LO_V];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_tlb[i] <= '0;
        end else if (w_op_write) begin
            r_tlb[w_wr_idx] <= w_new;
        end
    end

    logic        r_op_done, r_w_index, r_w_content;
    logic [31:0] r_index_out, r_hi_out, r_lo0_out, r_lo1_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_done   <= 1'b0;
            r_w_index   <= 1'b0;
            r_w_content <= 1'b0;
            r_index_out <= '0;
            r_hi_out    <= '0;
            r_lo0_out   <= '0;
            r_lo1_out   <= '0;
        end else begin
            r_op_done   <= bus.op_valid;
            r_w_index   <= w_op_probe;
            r_w_content <= w_op_read;
            if (w_op_probe) begin
                r_index_out <= w_pr_match ? 32'(w_pr_idx) : c_PROBE_MISS;
            end
            if (w_op_read) begin
                if (w_rd_entry.present) begin
                    r_hi_out  <= {w_rd_entry.vpn2, 5'b0, w_rd_entry.asid};
                    r_lo0_out <= lo_pack(w_rd_entry.page[0], w_rd_entry.g);
                    r_lo1_out <= lo_pack(w_rd_entry.page[1], w_rd_entry.g);
                end else begin
                    r_hi_out  <= '0;
                    r_lo0_out <= '0;
                    r_lo1_out <= '0;
                end
            end
        end
    end

    assign bus.op_done       = r_op_done;
    assign bus.w_index       = r_w_index;
    assign bus.w_content     = r_w_content;
    assign bus.index_out     = r_index_out;
    assign bus.entry_hi_out  = r_hi_out;
    assign bus.entry_lo0_out = r_lo0_out;
    assign bus.entry_lo1_out = r_lo1_out;

    // ---------------- Random / Wired ----------------
    // Random counts down from ENTRIES-1 to Wired, then wraps; Wired==ENTRIES-1 pins it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_random <= c_IDX_MAX;
            r_wired  <= '0;
        end else if (bus.wired_we) begin
            r_wired  <= bus.wired_in;
            r_random <= c_IDX_MAX;
        end else if (r_random == r_wired) begin
            r_random <= c_IDX_MAX;
        end else begin
            r_random <= r_random - 1'b1;
        end
    end

    assign bus.random_out = r_random;

    logic w_unused;
    assign w_unused = &{1'b0, bus.index[31:IDX_W],
                        bus.entry_hi[c_HI_VPN2_LSB-1:c_HI_ASID_MSB+1],
                        bus.entry_lo0[31:c_LO_PFN_MSB+1], bus.entry_lo1[31:c_LO_PFN_MSB+1]};
endmodule
`default_nettype wire

// File: tb/tb_tlb_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlb_assoc
//  Description : Self-checking bench for tlb_assoc: directed scenarios then
//                randomized traffic against a table-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_assoc;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tlb_assoc_if #(.IDX_W(IDX_W)) bus ();

    tlb_assoc #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ASID_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: raw written words per entry
    logic        m_present [ENTRIES];
    logic [18:0] m_vpn2    [ENTRIES];
    logic [7:0]  m_asid    [ENTRIES];
    logic        m_g       [ENTRIES];
    logic [31:0] m_lo      [ENTRIES][2];
    int          m_wired;
    int          load_cyc;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Random value as a function of cycles elapsed since the last reset/Wired load
    function automatic int exp_rand();
        return ENTRIES - 1 - ((cyc - load_cyc) % (ENTRIES - m_wired));
    endfunction

    function automatic int find(input logic [18:0] v, input logic [7:0] a);
        for (int i = 0; i < ENTRIES; i++)
            if (m_present[i] && m_vpn2[i] == v && (m_g[i] || m_asid[i] == a)) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < ENTRIES; i++) begin
            m_present[i] = 1'b0; m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
            m_lo[i][0] = '0; m_lo[i][1] = '0;
        end
        m_wired = 0;
    endtask

    // One clock: drive, predict from the model, clock, compare, update the model
    task automatic cycle(input logic req, input logic [31:0] va, input logic st,
                         input logic ov, input logic [1:0] o, input logic [31:0] idx,
                         input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1,
                         input logic wwe, input logic [3:0] win);
        int li, pi, ri, t;
        logic [31:0] sel, e_pa, e_idx, e_hi, e_lo0, e_lo1;
        logic e_hit, e_ref, e_inv, e_mod;
        bus.lk_req = req; bus.lk_vaddr = va; bus.lk_store = st;
        bus.op_valid = ov; bus.op = o; bus.index = idx;
        bus.entry_hi = hi; bus.entry_lo0 = lo0; bus.entry_lo1 = lo1;
        bus.wired_we = wwe; bus.wired_in = win;
        li = find(va[31:13], hi[7:0]);
        e_ref = (li < 0);
        sel = '0;
        if (li >= 0) sel = m_lo[li][va[12]];
        e_hit = !e_ref && sel[1] && (!st || sel[2]);
        e_inv = !e_ref && !sel[1];
        e_mod = !e_ref && sel[1] && st && !sel[2];
        e_pa  = e_hit ? {sel[25:6], va[11:0]} : 32'h0;
        pi = find(hi[31:13], hi[7:0]);
        e_idx = (pi < 0) ? 32'h8000_0000 : 32'(pi);
        ri = int'(idx[3:0]);
        e_hi  = m_present[ri] ? {m_vpn2[ri], 5'b0, m_asid[ri]} : 32'h0;
        e_lo0 = m_present[ri] ? {6'b0, m_lo[ri][0][25:1], m_g[ri]} : 32'h0;
        e_lo1 = m_present[ri] ? {6'b0, m_lo[ri][1][25:1], m_g[ri]} : 32'h0;
        t = (o == 2'd3) ? exp_rand() : ri;
        @(posedge clk); #1;
        chk("lk_valid", 32'(bus.lk_valid), 32'(req));
        if (req) begin
            chk("lk_hit", 32'(bus.lk_hit), 32'(e_hit));
            chk("lk_paddr", bus.lk_paddr, e_pa);
            chk("lk_refill", 32'(bus.lk_refill), 32'(e_ref));
            chk("lk_invalid", 32'(bus.lk_invalid), 32'(e_inv));
            chk("lk_modified", 32'(bus.lk_modified), 32'(e_mod));
        end
        chk("op_done", 32'(bus.op_done), 32'(ov));
        chk("w_index", 32'(bus.w_index), 32'(ov && o == 2'd0));
        chk("w_content", 32'(bus.w_content), 32'(ov && o == 2'd1));
        if (ov && o == 2'd0) chk("index_out", bus.index_out, e_idx);
        if (ov && o == 2'd1) begin
            chk("entry_hi_out", bus.entry_hi_out, e_hi);
            chk("entry_lo0_out", bus.entry_lo0_out, e_lo0);
            chk("entry_lo1_out", bus.entry_lo1_out, e_lo1);
        end
        if (ov && o[1]) begin
            m_present[t] = 1'b1; m_vpn2[t] = hi[31:13]; m_asid[t] = hi[7:0];
            m_g[t] = lo0[0] & lo1[0]; m_lo[t][0] = lo0; m_lo[t][1] = lo1;
        end
        if (wwe) begin m_wired = int'(win); load_cyc = cyc; end
        chk("random_out", 32'(bus.random_out), 32'(exp_rand()));
        bus.lk_req = 1'b0; bus.op_valid = 1'b0; bus.wired_we = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] va, input logic [7:0] asid, input logic st);
        cycle(1'b1, va, st, 1'b0, 2'd0, 32'h0, {24'h0, asid}, 32'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic op_cycle(input logic [1:0] o, input logic [31:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, o, idx, hi, lo0, lo1, 1'b0, 4'h0);
    endtask

    function automatic logic [31:0] mk_lo(input logic [19:0] pfn, input logic d, input logic v, input logic g);
        return {6'b0, pfn, 3'b010, d, v, g};
    endfunction

    initial begin
        int r;
        logic [18:0] pool [4];
        pool[0] = 19'h00200; pool[1] = 19'h00201; pool[2] = 19'h00600; pool[3] = 19'h7ffff;
        bus.lk_req = 0; bus.lk_vaddr = 0; bus.lk_store = 0; bus.op_valid = 0; bus.op = 0;
        bus.index = 0; bus.entry_hi = 0; bus.entry_lo0 = 0; bus.entry_lo1 = 0;
        bus.wired_we = 0; bus.wired_in = 0;
        clear_model();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        chk("rst lk_valid", 32'(bus.lk_valid), 32'h0);
        chk("rst lk_paddr", bus.lk_paddr, 32'h0);
        chk("rst op_done", 32'(bus.op_done), 32'h0);
        chk("rst index_out", bus.index_out, 32'h0);
        chk("rst entry_hi_out", bus.entry_hi_out, 32'h0);
        chk("rst random", 32'(bus.random_out), 32'd15);
        rst = 1'b0; load_cyc = cyc;

        // lookup after reset: refill
        lookup(32'h0040_1000, 8'h00, 1'b0);
        chk("first refill", 32'(bus.lk_refill), 32'h1);

        // write then translate
        op_cycle(2'd2, 32'd3, 32'h0040_0005, mk_lo(20'h00123, 1'b1, 1'b1, 1'b0), mk_lo(20'h00456, 1'b0, 1'b1, 1'b0));
        lookup(32'h0040_0ABC, 8'h05, 1'b0);
        chk("paddr 123ABC", bus.lk_paddr, 32'h0012_3ABC);
        lookup(32'h0040_1ABC, 8'h05, 1'b1);
        chk("store modified", 32'(bus.lk_modified), 32'h1);
        lookup(32'h0040_0ABC, 8'h06, 1'b0);
        chk("asid6 refill", 32'(bus.lk_refill), 32'h1);

        // probe / read
        op_cycle(2'd0, 32'h0, 32'h0040_0005, 32'h0, 32'h0);
        chk("probe idx3", bus.index_out, 32'd3);
        op_cycle(2'd0, 32'h0, 32'h0080_0005, 32'h0, 32'h0);
        chk("probe miss", bus.index_out, 32'h8000_0000);
        op_cycle(2'd1, 32'd3, 32'h0, 32'h0, 32'h0);
        chk("read hi", bus.entry_hi_out, 32'h0040_0005);
        op_cycle(2'd1, 32'd9, 32'h0, 32'h0, 32'h0);   // never written

        // Random sequence with Wired = 4
        cycle(1'b0, 0, 0, 1'b0, 2'd0, 0, 0, 0, 0, 1'b1, 4'd4);
        for (int k = 1; k <= 13; k++) begin
            cycle(1'b0, 0, 0, 1'b0, 2'd0, 0, 0, 0, 0, 1'b0, 4'd0);
            chk("random seq", 32'(bus.random_out), (k == 12) ? 32'd15 : 32'(15 - (k % 12)));
        end
        r = exp_rand();
        op_cycle(2'd3, 32'h0, 32'h0120_0011, mk_lo(20'hABCDE, 1'b1, 1'b1, 1'b1), mk_lo(20'h12345, 1'b1, 1'b0, 1'b1));
        op_cycle(2'd1, 32'(r), 32'h0, 32'h0, 32'h0);
        chk("wrnd read hi", bus.entry_hi_out, 32'h0120_0011);
        // WRITE_RND together with a Wired load uses the pre-load Random
        r = exp_rand();
        cycle(1'b0, 0, 0, 1'b1, 2'd3, 0, 32'h0140_0022, mk_lo(20'h00777, 1'b1, 1'b1, 1'b0), mk_lo(20'h00888, 1'b1, 1'b1, 1'b0), 1'b1, 4'd2);
        op_cycle(2'd1, 32'(r), 32'h0, 32'h0, 32'h0);
        chk("wrnd+wired hi", bus.entry_hi_out, 32'h0140_0022);

        // same-edge hazard
        cycle(1'b1, 32'h00C0_0123, 1'b0, 1'b1, 2'd2, 32'd5, 32'h00C0_0005,
              mk_lo(20'h00789, 1'b1, 1'b1, 1'b0), mk_lo(20'h0078A, 1'b1, 1'b1, 1'b0), 1'b0, 4'd0);
        chk("hazard refill", 32'(bus.lk_refill), 32'h1);
        lookup(32'h00C0_0123, 8'h05, 1'b0);
        chk("hazard hit", 32'(bus.lk_hit), 32'h1);

        // duplicate match: lowest index wins
        op_cycle(2'd2, 32'd7, 32'h0100_0005, mk_lo(20'h00BBB, 1'b1, 1'b1, 1'b0), mk_lo(20'h00BBB, 1'b1, 1'b1, 1'b0));
        op_cycle(2'd2, 32'd2, 32'h0100_0005, mk_lo(20'h00AAA, 1'b1, 1'b1, 1'b0), mk_lo(20'h00AAA, 1'b1, 1'b1, 1'b0));
        op_cycle(2'd0, 32'h0, 32'h0100_0005, 32'h0, 32'h0);
        chk("dup probe", bus.index_out, 32'd2);
        lookup(32'h0100_0004, 8'h05, 1'b0);
        chk("dup paddr", bus.lk_paddr, 32'h00AA_A004);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] hi, va;
            hi = {pool[$urandom_range(0, 3)], 5'($urandom), 8'(5 + $urandom_range(0, 1))};
            va = {pool[$urandom_range(0, 3)], 13'($urandom)};
            cycle(1'($urandom_range(0, 9) < 7), va, 1'($urandom), 1'($urandom),
                  2'($urandom), $urandom, hi, $urandom, $urandom,
                  1'($urandom_range(0, 29) == 0), 4'($urandom));
        end

        // reset mid-operation
        bus.lk_req = 1'b1; bus.lk_vaddr = 32'h0A00_0000; bus.op_valid = 1'b1; bus.op = 2'd2;
        bus.index = 32'd9; bus.entry_hi = 32'h0A00_0005;
        bus.entry_lo0 = mk_lo(20'h00999, 1'b1, 1'b1, 1'b0); bus.entry_lo1 = bus.entry_lo0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("midrst lk_valid", 32'(bus.lk_valid), 32'h0);
        chk("midrst op_done", 32'(bus.op_done), 32'h0);
        chk("midrst random", 32'(bus.random_out), 32'd15);
        @(posedge clk); #1;
        bus.lk_req = 1'b0; bus.op_valid = 1'b0;
        clear_model();
        rst = 1'b0; load_cyc = cyc;
        op_cycle(2'd0, 32'h0, 32'h0A00_0005, 32'h0, 32'h0);
        chk("midrst probe miss", bus.index_out, 32'h8000_0000);
        lookup(32'h0A00_0000, 8'h05, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
